user_bram_wb: RTL and testbench



---
 rtl/user_bram_wb.sv | 205 ++++++++++++++++++++
 tb/tb_user_bram_wb.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/user_bram_wb.sv
// user_bram_wb: Wishbone-attached block-RAM slave with programmable wait
// states, an error response for misaligned accesses, abort on request
// withdrawal, and a one-word sequential-read prefetch buffer.
// The read-data port is named do_o because "do" is a reserved word.
module user_bram_wb #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH_LOG2 = 10,
    parameter int DELAYS     = 10,
    parameter int PREFETCH   = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    en,
    input  logic [DATA_WIDTH/8-1:0] we,
    input  logic [DATA_WIDTH-1:0]   di,
    input  logic [31:0]             address,
    output logic [DATA_WIDTH-1:0]   do_o,
    output logic                    ack,
    output logic                    err,
    output logic                    busy
);

    localparam int NB    = DATA_WIDTH / 8;
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [7:0] DELAY_INIT = 8'(DELAYS);
    localparam bit PF_EN = (PREFETCH != 0);
    localparam logic [DEPTH_LOG2-1:0] IDX_ONE = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        RESP    = 2'd2,
        PF_FILL = 2'd3
    } state_t;

    // Overlay the written byte lanes of new_w onto old_w.
    function automatic logic [DATA_WIDTH-1:0] merge_lanes(
        input logic [DATA_WIDTH-1:0] old_w,
        input logic [DATA_WIDTH-1:0] new_w,
        input logic [NB-1:0]         strb
    );
        logic [DATA_WIDTH-1:0] res;
        res = old_w;
        for (int i = 0; i < NB; i++) begin
            if (strb[i]) begin
                res[8*i +: 8] = new_w[8*i +: 8];
            end else begin
                res[8*i +: 8] = old_w[8*i +: 8];
            end
        end
        return res;
    endfunction

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    state_t                state_q, state_d;
    logic [7:0]            cnt_q, cnt_d;
    logic                  ack_q, ack_d;
    logic                  err_q, err_d;
    logic                  busy_q, busy_d;
    logic [DATA_WIDTH-1:0] do_q, do_d;
    logic                  pf_valid_q, pf_valid_d;
    logic [DEPTH_LOG2-1:0] pf_addr_q, pf_addr_d;
    logic [DATA_WIDTH-1:0] pf_data_q, pf_data_d;
    logic [DEPTH_LOG2-1:0] last_idx_q, last_idx_d;
    logic                  fill_q, fill_d;

    logic [DEPTH_LOG2-1:0] idx_s;
    logic [DEPTH_LOG2-1:0] next_idx_s;
    logic                  is_read_s;
    logic                  mem_wr_s;
    logic                  unused_addr_s;

    assign idx_s         = address[DEPTH_LOG2+1:2];
    assign next_idx_s    = last_idx_q + IDX_ONE;
    assign is_read_s     = (we == {NB{1'b0}});
    assign unused_addr_s = ^address[31:DEPTH_LOG2+2];

    assign do_o = do_q;
    assign ack  = ack_q;
    assign err  = err_q;
    assign busy = busy_q;

    // Next-state, response and prefetch-buffer logic.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ack_d      = 1'b0;
        err_d      = 1'b0;
        do_d       = {DATA_WIDTH{1'b0}};
        pf_valid_d = pf_valid_q;
        pf_addr_d  = pf_addr_q;
        pf_data_d  = pf_data_q;
        last_idx_d = last_idx_q;
        fill_d     = fill_q;
        mem_wr_s   = 1'b0;
        case (state_q)
            IDLE: begin
                if (en) begin
                    if (address[1:0] != 2'b00) begin
                        state_d = RESP;
                        err_d   = 1'b1;
                        fill_d  = 1'b0;
                    end else if (PF_EN && is_read_s && pf_valid_q && (idx_s == pf_addr_q)) begin
                        state_d    = RESP;
                        ack_d      = 1'b1;
                        do_d       = pf_data_q;
                        fill_d     = 1'b1;
                        last_idx_d = idx_s;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = DELAY_INIT;
                        fill_d  = 1'b0;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                if (!en) begin
                    // Master withdrew the request: abandon with no side effects.
                    state_d = IDLE;
                end else if (cnt_q == 8'd0) begin
                    state_d    = RESP;
                    ack_d      = 1'b1;
                    do_d       = mem[idx_s];
                    last_idx_d = idx_s;
                    if (is_read_s) begin
                        fill_d = PF_EN;
                    end else begin
                        mem_wr_s = 1'b1;
                        fill_d   = 1'b0;
                        // Keep the prefetch buffer coherent with the array.
                        if (idx_s == pf_addr_q) begin
                            pf_data_d = merge_lanes(pf_data_q, di, we);
                        end else begin
                            pf_data_d = pf_data_q;
                        end
                    end
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            RESP: begin
                if (fill_q) begin
                    state_d = PF_FILL;
                end else begin
                    state_d = IDLE;
                end
            end
            PF_FILL: begin
                pf_addr_d  = next_idx_s;
                pf_data_d  = mem[next_idx_s];
                pf_valid_d = 1'b1;
                fill_d     = 1'b0;
                state_d    = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // Control, output and prefetch registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= 8'd0;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
            do_q       <= {DATA_WIDTH{1'b0}};
            pf_valid_q <= 1'b0;
            pf_addr_q  <= {DEPTH_LOG2{1'b0}};
            pf_data_q  <= {DATA_WIDTH{1'b0}};
            last_idx_q <= {DEPTH_LOG2{1'b0}};
            fill_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
            busy_q     <= busy_d;
            do_q       <= do_d;
            pf_valid_q <= pf_valid_d;
            pf_addr_q  <= pf_addr_d;
            pf_data_q  <= pf_data_d;
            last_idx_q <= last_idx_d;
            fill_q     <= fill_d;
        end
    end

    // Memory array write port with per-byte-lane enables (contents not reset).
    always_ff @(posedge clk) begin
        if (mem_wr_s) begin
            for (int i = 0; i < NB; i++) begin
                if (we[i]) begin
                    mem[idx_s][8*i +: 8] <= di[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_user_bram_wb.sv
// Directed testbench for user_bram_wb: three instances cover the default
// configuration (DELAYS=10, prefetch on), zero wait states, and prefetch off.
module tb_user_bram_wb;

    logic        clk;
    logic        reset;
    logic [2:0]  en_v;
    logic [3:0]  we;
    logic [31:0] di;
    logic [31:0] address;
    logic [31:0] do_v [3];
    logic [2:0]  ack_v;
    logic [2:0]  err_v;
    logic [2:0]  busy_v;

    int n_assert;
    int n_fail;

    user_bram_wb #(.DATA_WIDTH(32), .DEPTH_LOG2(10), .DELAYS(10), .PREFETCH(1)) u_main (
        .clk(clk), .reset(reset), .en(en_v[0]), .we(we), .di(di), .address(address),
        .do_o(do_v[0]), .ack(ack_v[0]), .err(err_v[0]), .busy(busy_v[0])
    );

    user_bram_wb #(.DATA_WIDTH(32), .DEPTH_LOG2(10), .DELAYS(0), .PREFETCH(1)) u_fast (
        .clk(clk), .reset(reset), .en(en_v[1]), .we(we), .di(di), .address(address),
        .do_o(do_v[1]), .ack(ack_v[1]), .err(err_v[1]), .busy(busy_v[1])
    );

    user_bram_wb #(.DATA_WIDTH(32), .DEPTH_LOG2(10), .DELAYS(3), .PREFETCH(0)) u_nopf (
        .clk(clk), .reset(reset), .en(en_v[2]), .we(we), .di(di), .address(address),
        .do_o(do_v[2]), .ack(ack_v[2]), .err(err_v[2]), .busy(busy_v[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One complete transaction on instance s, measuring latency in clock edges.
    task automatic txn(input int s, input logic [31:0] a, input logic [3:0] w,
                       input logic [31:0] d, input int exp_lat, input bit exp_err,
                       input bit chk_do, input logic [31:0] exp_do, input string tag);
        int lat;
        bit seen;
        bit dirty;
        @(negedge clk);
        address = a; we = w; di = d; en_v[s] = 1'b1;
        lat = 0; seen = 1'b0; dirty = 1'b0;
        while (!seen && lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (ack_v[s] || err_v[s]) seen = 1'b1;
            else if (do_v[s] !== 32'h0) dirty = 1'b1;
        end
        chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        chk({tag, "_do0_before"}, {63'd0, dirty}, 64'd0);
        if (exp_err) begin
            chk({tag, "_err"}, {63'd0, err_v[s]}, 64'd1);
            chk({tag, "_noack"}, {63'd0, ack_v[s]}, 64'd0);
            chk({tag, "_do_err"}, {32'd0, do_v[s]}, 64'd0);
        end else begin
            chk({tag, "_ack"}, {63'd0, ack_v[s]}, 64'd1);
            chk({tag, "_noerr"}, {63'd0, err_v[s]}, 64'd0);
        end
        if (chk_do) chk({tag, "_data"}, {32'd0, do_v[s]}, {32'd0, exp_do});
        @(negedge clk);
        en_v[s] = 1'b0;
        @(posedge clk); #1;
        chk({tag, "_pulse"}, {62'd0, ack_v[s], err_v[s]}, 64'd0);
        chk({tag, "_do0_after"}, {32'd0, do_v[s]}, 64'd0);
        for (int i = 0; i < 4 && busy_v[s]; i++) begin
            @(posedge clk); #1;
        end
        chk({tag, "_idle"}, {63'd0, busy_v[s]}, 64'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acks;
        n_assert = 0;
        n_fail   = 0;
        reset = 1'b1; en_v = 3'b000; we = 4'h0; di = 32'h0; address = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        // Reset state of every instance
        for (int s = 0; s < 3; s++) begin
            chk("rst_ack", {63'd0, ack_v[s]}, 64'd0);
            chk("rst_err", {63'd0, err_v[s]}, 64'd0);
            chk("rst_busy", {63'd0, busy_v[s]}, 64'd0);
            chk("rst_do", {32'd0, do_v[s]}, 64'd0);
        end
        @(negedge clk);
        reset = 1'b0;

        // Full-latency write and read-back
        txn(0, 32'h3800_0010, 4'hF, 32'hDEAD_BEEF, 12, 1'b0, 1'b0, 32'h0, "wr_beef");
        txn(0, 32'h3800_0010, 4'h0, 32'h0, 12, 1'b0, 1'b1, 32'hDEAD_BEEF, "rd_beef");

        // Byte lanes: lanes 0 and 2 written
        txn(0, 32'h0000_0020, 4'hF, 32'h1122_3344, 12, 1'b0, 1'b0, 32'h0, "wr_lane_init");
        txn(0, 32'h0000_0020, 4'b0101, 32'hAABB_CCDD, 12, 1'b0, 1'b0, 32'h0, "wr_lane");
        txn(0, 32'h0000_0020, 4'h0, 32'h0, 12, 1'b0, 1'b1, 32'h11BB_33DD, "rd_lane");

        // Sequential prefetch hit
        txn(0, 32'h0000_0000, 4'hF, 32'h0102_0304, 12, 1'b0, 1'b0, 32'h0, "wr_w0");
        txn(0, 32'h0000_0004, 4'hF, 32'h0506_0708, 12, 1'b0, 1'b0, 32'h0, "wr_w1");
        txn(0, 32'h0000_0000, 4'h0, 32'h0, 12, 1'b0, 1'b1, 32'h0102_0304, "rd_w0_miss");
        txn(0, 32'h0000_0004, 4'h0, 32'h0, 1, 1'b0, 1'b1, 32'h0506_0708, "rd_w1_hit");

        // Wrap from the top word to word 0
        txn(0, 32'h0000_0FFC, 4'hF, 32'hCAFE_F00D, 12, 1'b0, 1'b0, 32'h0, "wr_top");
        txn(0, 32'h0000_0FFC, 4'h0, 32'h0, 12, 1'b0, 1'b1, 32'hCAFE_F00D, "rd_top");
        txn(0, 32'h0000_0000, 4'h0, 32'h0, 1, 1'b0, 1'b1, 32'h0102_0304, "rd_wrap_hit");

        // Write into the prefetched word (word 1) must merge into the buffer
        txn(0, 32'h0000_0004, 4'b0001, 32'h0000_0055, 12, 1'b0, 1'b0, 32'h0, "wr_coh");
        txn(0, 32'h0000_0004, 4'h0, 32'h0, 1, 1'b0, 1'b1, 32'h0506_0755, "rd_coh_hit");

        // Misaligned accesses: error pulse, memory untouched
        txn(0, 32'h0000_0006, 4'hF, 32'hFFFF_FFFF, 1, 1'b1, 1'b0, 32'h0, "wr_misal");
        txn(0, 32'h0000_0002, 4'h0, 32'h0, 1, 1'b1, 1'b0, 32'h0, "rd_misal");
        txn(0, 32'h0000_0004, 4'h0, 32'h0, 12, 1'b0, 1'b1, 32'h0506_0755, "rd_after_misal");

        // Abort after 4 WAIT cycles
        @(negedge clk);
        address = 32'h0000_0010; we = 4'hF; di = 32'h1234_5678; en_v[0] = 1'b1;
        acks = 0;
        repeat (5) begin
            @(posedge clk); #1;
            if (ack_v[0]) acks++;
        end
        @(negedge clk);
        en_v[0] = 1'b0;
        repeat (12) begin
            @(posedge clk); #1;
            if (ack_v[0]) acks++;
        end
        chk("abort_noack", 64'(acks), 64'd0);
        chk("abort_idle", {63'd0, busy_v[0]}, 64'd0);
        txn(0, 32'h0000_0010, 4'h0, 32'h0, 12, 1'b0, 1'b1, 32'hDEAD_BEEF, "rd_after_abort");

        // Reset asserted mid-WAIT of a write
        @(negedge clk);
        address = 32'h0000_0010; we = 4'hF; di = 32'h0BAD_F00D; en_v[0] = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("midrst_busy_before", {63'd0, busy_v[0]}, 64'd1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("midrst_ack", {63'd0, ack_v[0]}, 64'd0);
        chk("midrst_busy", {63'd0, busy_v[0]}, 64'd0);
        en_v[0] = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        txn(0, 32'h0000_0010, 4'h0, 32'h0, 12, 1'b0, 1'b1, 32'hDEAD_BEEF, "rd_after_midrst");

        // en held high across RESP: a single ack within the window
        @(negedge clk);
        address = 32'h0000_0030; we = 4'hF; di = 32'h0000_0077; en_v[0] = 1'b1;
        acks = 0;
        repeat (14) begin
            @(posedge clk); #1;
            if (ack_v[0]) acks++;
        end
        @(negedge clk);
        en_v[0] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("b2b_one_ack", 64'(acks), 64'd1);
        chk("b2b_idle", {63'd0, busy_v[0]}, 64'd0);
        txn(0, 32'h0000_0030, 4'h0, 32'h0, 12, 1'b0, 1'b1, 32'h0000_0077, "rd_b2b");

        // Zero wait states
        txn(1, 32'h0000_0040, 4'hF, 32'hA1A2_A3A4, 2, 1'b0, 1'b0, 32'h0, "d0_wr0");
        txn(1, 32'h0000_0044, 4'hF, 32'hB1B2_B3B4, 2, 1'b0, 1'b0, 32'h0, "d0_wr1");
        txn(1, 32'h0000_0040, 4'h0, 32'h0, 2, 1'b0, 1'b1, 32'hA1A2_A3A4, "d0_rd0");
        txn(1, 32'h0000_0044, 4'h0, 32'h0, 1, 1'b0, 1'b1, 32'hB1B2_B3B4, "d0_rd1_hit");

        // Prefetch disabled: sequential reads pay full latency
        txn(2, 32'h0000_0000, 4'hF, 32'hC0C1_C2C3, 5, 1'b0, 1'b0, 32'h0, "npf_wr0");
        txn(2, 32'h0000_0004, 4'hF, 32'hD0D1_D2D3, 5, 1'b0, 1'b0, 32'h0, "npf_wr1");
        txn(2, 32'h0000_0000, 4'h0, 32'h0, 5, 1'b0, 1'b1, 32'hC0C1_C2C3, "npf_rd0");
        txn(2, 32'h0000_0004, 4'h0, 32'h0, 5, 1'b0, 1'b1, 32'hD0D1_D2D3, "npf_rd1");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
